// File: rtl/leb128_pkg.sv
// rtl/leb128_pkg.sv - shared LEB128 constants, FSM state and decoded-word record
package leb128_pkg;

    localparam int LEB128_CONT_BIT = 7;
    localparam int LEB128_CHUNK_W  = 7;
    localparam int U32_MAX_LEN     = 5;

    typedef enum logic {
        ACC,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  len;
        logic        err;
    } u32_dec_t;

endpackage

// File: rtl/unpack_u32_stream_if.sv
// rtl/unpack_u32_stream_if.sv - byte-in / word-out handshake bundle of the u32 LEB128 decoder
interface unpack_u32_stream_if;

    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [2:0]  o_len;
    logic        o_err;
    logic        o_valid;
    logic        o_ready;

    modport slave (
        input  i_data, i_valid, o_ready,
        output i_ready, o_data, o_len, o_err, o_valid
    );

    modport master (
        output i_data, i_valid, o_ready,
        input  i_ready, o_data, o_len, o_err, o_valid
    );

endinterface

// File: rtl/leb128_chunk_place.sv
// rtl/leb128_chunk_place.sv - places one 7-bit LEB128 chunk into a 32-bit accumulator by byte index
module leb128_chunk_place
    import leb128_pkg::*;
(
    input  logic [2:0]                i_idx,
    input  logic [LEB128_CHUNK_W-1:0] i_chunk,
    input  logic [31:0]               i_acc,
    output logic [31:0]               o_acc,
    output logic                      o_ovf
);

    always_comb begin
        o_acc = i_acc;
        o_ovf = 1'b0;
        case (i_idx)
            3'd0: o_acc[6:0]   = i_chunk;
            3'd1: o_acc[13:7]  = i_chunk;
            3'd2: o_acc[20:14] = i_chunk;
            3'd3: o_acc[27:21] = i_chunk;
            // Only four payload bits fit in a u32; anything above them is overflow.
            3'd4: begin
                o_acc[31:28] = i_chunk[3:0];
                o_ovf        = |i_chunk[6:4];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unpack_u32_stream.sv
// rtl/unpack_u32_stream.sv - streaming unsigned LEB128 to u32 decoder with length and error reporting
module unpack_u32_stream
    import leb128_pkg::*;
#(
    parameter bit STRICT  = 1'b1,
    parameter int MAX_LEN = 5
) (
    input  logic                clk,
    input  logic                rst,
    unpack_u32_stream_if.slave  bus
);

    if (MAX_LEN != U32_MAX_LEN) begin : g_bad_max_len
        $error("unpack_u32_stream: MAX_LEN must be 5");
    end

    state_e      r_state, w_state_nxt;
    logic [31:0] r_acc, w_acc_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
    u32_dec_t    r_out, w_out_nxt;
    logic        r_valid, w_valid_nxt;

    logic        w_in_beat;
    logic        w_out_beat;
    logic        w_term;
    logic [2:0]  w_cnt_inc;
    logic [31:0] w_placed;
    logic        w_ovf;
    logic        w_err_acc;

    leb128_chunk_place u_place (
        .i_idx   (r_cnt),
        .i_chunk (bus.i_data[LEB128_CHUNK_W-1:0]),
        .i_acc   (r_acc),
        .o_acc   (w_placed),
        .o_ovf   (w_ovf)
    );

    assign bus.i_ready = ~r_valid | bus.o_ready;
    assign w_in_beat   = bus.i_valid & bus.i_ready;
    assign w_out_beat  = r_valid & bus.o_ready;
    assign w_term      = ~bus.i_data[LEB128_CONT_BIT];
    assign w_cnt_inc   = (r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1;
    assign w_err_acc   = r_err | (STRICT & w_ovf);

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid & ~w_out_beat;

        if (w_in_beat) begin
            case (r_state)
                ACC: begin
                    if (w_term) begin
                        w_out_nxt   = '{data: w_placed, len: w_cnt_inc, err: w_err_acc};
                        w_valid_nxt = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_err_nxt   = 1'b0;
                    end else if (r_cnt == 3'(U32_MAX_LEN - 1)) begin
                        // A fifth byte that still continues can never fit; swallow the rest.
                        w_state_nxt = DRAIN;
                        w_acc_nxt   = w_placed;
                        w_cnt_nxt   = w_cnt_inc;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_acc_nxt   = w_placed;
                        w_cnt_nxt   = w_cnt_inc;
                        w_err_nxt   = w_err_acc;
                    end
                end
                DRAIN: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_term) begin
                        w_out_nxt   = '{data: r_acc, len: w_cnt_inc, err: 1'b1};
                        w_valid_nxt = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = ACC;
                    end
                end
                default: w_state_nxt = ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.o_data  = r_out.data;
    assign bus.o_len   = r_out.len;
    assign bus.o_err   = r_out.err;
    assign bus.o_valid = r_valid;

endmodule

// File: doc/unpack_u32_stream.md
Name: unpack_u32_stream

Overview:
- Streaming LEB128 decoder for unsigned 32-bit values; the receive-side counterpart of the combinational u32 packer.
- Consumes one encoded byte per cycle over a valid/ready input and emits one 32-bit value per terminating byte over a valid/ready output.
- Reports the encoded length and an error flag.
- Sits between a byte-stream source (FIFO, deframer) and word-level consumers.

Parameters:
- STRICT, default 1: when 1, set o_err if byte index 4 carries nonzero bits [6:4] (value exceeds 32 bits).
- MAX_LEN, default 5: maximum legal encoded length in bytes; fixed at 5 for u32. Any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_data  in  8  encoded byte; bit 7 = continuation, bits 6:0 = payload chunk
- i_valid  in  1  i_data valid
- i_ready  out  1  decoder accepts i_data this cycle
- o_data  out  32  decoded value
- o_len  out  3  bytes consumed for this value, 1..7, saturating at 7
- o_err  out  1  malformed or overflowing encoding
- o_valid  out  1  o_data, o_len and o_err are valid
- o_ready  in  1  consumer accepts output

Behaviour:
- Reset (rst=1 at a clk edge):
  - o_valid=0, o_data=0, o_len=0, o_err=0.
  - Accumulator=0, byte count=0, error flag=0, state=ACC.
  - Reset wins over every other event and discards any partial value.
- Handshakes:
  - Input beat = i_valid & i_ready.
  - Output beat = o_valid & o_ready.
  - i_ready = !o_valid | o_ready, combinational from o_valid/o_ready only; it never depends on i_valid.
  - o_valid rises the cycle after the terminating byte is accepted. Once o_valid is high, o_data, o_len and o_err are held stable until the output beat.
- State ACC, on each input beat with byte index k = count:
  - k<=3: acc[7k+6:7k] <= i_data[6:0].
  - k==4: acc[31:28] <= i_data[3:0]. If STRICT and i_data[6:4]!=0, set the error flag.
  - count increments, saturating at 7.
  - i_data[7]==0 (terminator): load the output register with o_data=acc including this byte, o_len=count+1, o_err=error flag. Set o_valid=1, clear acc, count and error flag, stay in ACC.
  - i_data[7]==1 and k==4: set the error flag and go to DRAIN.
- State DRAIN:
  - Accepts and discards bytes, incrementing count (saturating).
  - On the first byte with bit 7 == 0: emit o_data = low 32 bits accumulated, o_len = saturated count, o_err=1. Clear state and return to ACC.
- Throughput and latency:
  - One byte per cycle sustained.
  - Back-to-back single-byte values give o_valid high every cycle while o_ready=1.
  - A terminator accepted in the same cycle as an output beat overwrites the output register with no bubble.
- Bits above those written are zero. Non-canonical encodings (for example 0x80 0x00) are legal: value 0, len 2, err 0.
- o_valid=0 with a partial value in progress is the normal idle condition. There is no timeout.

Decomposition:
- Package leb128_pkg:
  - LEB128_CONT_BIT=7
  - LEB128_CHUNK_W=7
  - U32_MAX_LEN=5
  - typedef state_e {ACC, DRAIN}
  - typedef u32_dec_t {data[31:0], len[2:0], err}
- One natural sub-module, leb128_chunk_place: combinational placement of a 7-bit chunk into a 32-bit accumulator by byte index, plus the overflow check. It is reusable by a future u64 decoder.
- Output register and FSM stay in the top.

Test Plan:
- 0x00 -> o_data=0x00000000, o_len=1, o_err=0; o_valid appears 1 cycle after the input beat.
- 0xE5,0x8E,0x26 back-to-back, o_ready=1 -> o_data=624485 (0x00098765), o_len=3, o_err=0.
- 0xFF,0xFF,0xFF,0xFF,0x0F -> o_data=0xFFFFFFFF, len=5, err=0. Then 0xFF,0xFF,0xFF,0xFF,0x1F with STRICT=1 -> err=1, o_data=0xFFFFFFFF; with STRICT=0 -> err=0.
- 0x80 x5, then 0x80, 0x01 -> a single output with err=1, len=7, o_data=0. The following 0x05 decodes cleanly: data=5, len=1, err=0.
- Stream 0x01,0x02,0x03 with o_ready held low 4 cycles -> o_valid=1 with data=1 held stable, i_ready=0. On o_ready=1, outputs 1,2,3 follow on consecutive cycles with none lost.
- Send 0xE5,0x8E, assert rst for 1 cycle, then send 0x07 -> all outputs at reset values during reset; the next output is data=7, len=1, err=0 with no residue from the partial value.
